// File: rtl/demux_skid_w4_if.sv
// Handshake bundle for demux_skid_w4: one producer stream in, two consumer channels out.
// The master modport is the producer/consumer side and the slave modport is the demux.
interface demux_skid_w4_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] y0_data;
  logic             y1_valid;
  logic             y1_ready;
  logic [WIDTH-1:0] y1_data;
  logic [CW-1:0]    cnt0;
  logic [CW-1:0]    cnt1;

  modport master (
    output in_valid, in_data, in_sel, y0_ready, y1_ready,
    input  in_ready, y0_valid, y0_data, y1_valid, y1_data, cnt0, cnt1
  );

  modport slave (
    input  in_valid, in_data, in_sel, y0_ready, y1_ready,
    output in_ready, y0_valid, y0_data, y1_valid, y1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demux_skid_w4.sv
// 1-to-2 demultiplexing buffer: the producer word is steered by in_sel into one of two
// registered FIFOs, each draining through its own valid/ready handshake.
module demux_skid_w4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input logic             clk,
  input logic             rst,
  demux_skid_w4_if.slave  bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [AW-1:0]    wr_ptr_q [2];
  logic [AW-1:0]    wr_ptr_d [2];
  logic [AW-1:0]    rd_ptr_q [2];
  logic [AW-1:0]    rd_ptr_d [2];
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       valid;
  logic             in_ready;

  // in_ready looks only at the selected channel's registered count, never at y*_ready.
  always_comb begin
    in_ready = bus.in_sel ? (cnt_q[1] != CW'(DEPTH)) : (cnt_q[0] != CW'(DEPTH));
    push[0]  = bus.in_valid & in_ready & ~bus.in_sel;
    push[1]  = bus.in_valid & in_ready & bus.in_sel;
    valid[0] = (cnt_q[0] != '0);
    valid[1] = (cnt_q[1] != '0);
    pop[0]   = valid[0] & bus.y0_ready;
    pop[1]   = valid[1] & bus.y1_ready;
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      cnt_d[k]    = cnt_q[k];
      if (push[k]) wr_ptr_d[k] = wr_ptr_q[k] + 1'b1;
      if (pop[k])  rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
      unique case ({push[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        cnt_q[k]    <= cnt_d[k];
      end
    end
  end

  // Storage is not reset; empty channels mask their head to zero instead.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= bus.in_data;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.y0_valid = valid[0];
  assign bus.y1_valid = valid[1];
  assign bus.y0_data  = valid[0] ? mem_q[0][rd_ptr_q[0]] : '0;
  assign bus.y1_data  = valid[1] ? mem_q[1][rd_ptr_q[1]] : '0;
  assign bus.cnt0     = cnt_q[0];
  assign bus.cnt1     = cnt_q[1];
endmodule

// File: tb/tb_demux_skid_w4.sv
// Self-checking bench for demux_skid_w4: directed scenarios plus random traffic,
// compared cycle by cycle against two ideal FIFO queues.
module tb_demux_skid_w4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  demux_skid_w4_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  demux_skid_w4 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_ready(input logic sel);
    return sel ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
  endfunction

  task automatic drive(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.y0_ready = r0;
    bus.y1_ready = r1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_ready(bus.in_sel)));
    check({tag, ".y0_valid"}, 32'(bus.y0_valid), 32'(q0.size() != 0));
    check({tag, ".y1_valid"}, 32'(bus.y1_valid), 32'(q1.size() != 0));
    check({tag, ".y0_data"}, 32'(bus.y0_data), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
    check({tag, ".y1_data"}, 32'(bus.y1_data), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
    check({tag, ".cnt0"}, 32'(bus.cnt0), 32'(q0.size()));
    check({tag, ".cnt1"}, 32'(bus.cnt1), 32'(q1.size()));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input string tag, input logic v, input logic sel,
                      input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    logic push0, push1, pop0, pop1;
    drive(v, sel, d, r0, r1);
    #1;
    check_outputs(tag);
    push0 = v && exp_ready(sel) && !sel;
    push1 = v && exp_ready(sel) && sel;
    pop0  = (q0.size() != 0) && r0;
    pop1  = (q1.size() != 0) && r1;
    @(posedge clk);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (push0) q0.push_back(d);
    if (push1) q1.push_back(d);
    @(negedge clk);
  endtask

  initial begin
    logic v, sel, r0, r1, stalled;
    logic [WIDTH-1:0] d;
    logic [CW-1:0] c0, c1;

    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Push 0x5 to ch0 then 0xA to ch1 with both consumers stalled.
    step("t1_push5", 1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
    check("t1.y0_data", 32'(bus.y0_data), 32'h5);
    step("t1_pushA", 1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
    check("t1.y1_data", 32'(bus.y1_data), 32'hA);
    check("t1.cnt0", 32'(bus.cnt0), 32'd1);
    check("t1.cnt1", 32'(bus.cnt1), 32'd1);
    step("t1_drain", 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

    // Fill ch0, then show head-of-line blocking only applies to the selected channel.
    step("t2_push1", 1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    step("t2_push2", 1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    #1;
    check("t2.full_ready", 32'(bus.in_ready), 32'd0);
    check("t2.cnt0", 32'(bus.cnt0), 32'd2);
    bus.in_sel = 1'b1;
    #1;
    check("t2.switch_ready", 32'(bus.in_ready), 32'd1);
    step("t2_push3", 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
    check("t2.y1_data", 32'(bus.y1_data), 32'h3);

    // Full ch0 with a pop in the same cycle: the producer still waits one cycle.
    drive(1'b1, 1'b0, 4'h4, 1'b1, 1'b0);
    #1;
    check("t3.ready_full_pop", 32'(bus.in_ready), 32'd0);
    step("t3_pop1", 1'b1, 1'b0, 4'h4, 1'b1, 1'b0);
    check("t3.ready_after", 32'(bus.in_ready), 32'd1);
    step("t3_push4", 1'b1, 1'b0, 4'h4, 1'b0, 1'b0);
    check("t3.head2", 32'(bus.y0_data), 32'h2);
    step("t3_drain2", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    check("t3.head4", 32'(bus.y0_data), 32'h4);
    step("t3_drain4", 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

    // Steady stream through ch1 with its consumer always ready.
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        check("t4.cnt1", 32'(bus.cnt1), 32'd1);
        check("t4.head", 32'(bus.y1_data), 32'(i - 1));
      end
      step("t4_stream", 1'b1, 1'b1, WIDTH'(i), 1'b0, 1'b1);
      check("t4.in_ready", 32'(bus.in_ready), 32'd1);
    end
    step("t4_tail", 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream with cnt0=2, cnt1=1.
    step("t5_fill_a", 1'b1, 1'b0, 4'h8, 1'b0, 1'b0);
    step("t5_fill_b", 1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
    step("t5_fill_c", 1'b1, 1'b1, 4'hC, 1'b0, 1'b0);
    check("t5.cnt0_pre", 32'(bus.cnt0), 32'd2);
    check("t5.cnt1_pre", 32'(bus.cnt1), 32'd1);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("t5.y0_valid_async", 32'(bus.y0_valid), 32'd0);
    check("t5.y1_valid_async", 32'(bus.y1_valid), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5.cnt0_post", 32'(bus.cnt0), 32'd0);
    check("t5.cnt1_post", 32'(bus.cnt1), 32'd0);
    @(negedge clk);
    step("t5_push7", 1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
    check("t5.y0_data7", 32'(bus.y0_data), 32'h7);

    // Idle producer with a wandering in_sel: nothing is written.
    step("t6_prep", 1'b1, 1'b1, 4'hE, 1'b0, 1'b0);
    c0 = bus.cnt0;
    c1 = bus.cnt1;
    for (int i = 0; i < 10; i++) begin
      step("t6_idle", 1'b0, 1'($urandom_range(1)), WIDTH'($urandom), 1'b0, 1'b0);
      check("t6.cnt0", 32'(bus.cnt0), 32'(c0));
      check("t6.cnt1", 32'(bus.cnt1), 32'(c1));
    end

    // Random traffic; a stalled producer holds its word and destination.
    stalled = 1'b0;
    v = 1'b0;
    sel = 1'b0;
    d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!stalled) begin
        v   = ($urandom_range(3) != 0);
        sel = 1'($urandom_range(1));
        d   = WIDTH'($urandom);
      end
      r0 = ($urandom_range(2) != 0);
      r1 = ($urandom_range(3) == 0);
      stalled = v && !exp_ready(sel);
      step("rand", v, sel, d, r0, r1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_skid_w4.md
Name: demux_skid_w4

Overview:
- 1-to-2 demultiplexing buffer for the 4-bit datapath. It is the distribution counterpart of the 2:1 selection mux.
- One producer stream is steered by a select bit into one of two consumer channels. Each channel holds a small registered FIFO with its own valid/ready handshake.
- Used where a pipeline-stage result must be routed to one of two downstream stages that can stall independently.

Parameters:
- WIDTH, 4, data width per word.
- DEPTH, 2, entries per channel FIFO. Must be a power of two, ≥2.
- CW, 2, occupancy count width. Must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer word valid.
- in_ready  output  1  demux can accept into the selected channel.
- in_data  input  WIDTH  producer word.
- in_sel  input  1  destination: 0 = channel 0, 1 = channel 1.
- y0_valid  output  1  channel 0 head valid.
- y0_ready  input  1  channel 0 consumer ready.
- y0_data  output  WIDTH  channel 0 head word.
- y1_valid  output  1  channel 1 head valid.
- y1_ready  input  1  channel 1 consumer ready.
- y1_data  output  WIDTH  channel 1 head word.
- cnt0  output  CW  channel 0 occupancy.
- cnt1  output  CW  channel 1 occupancy.

Behaviour:
- Reset (rst=0, asynchronous): all pointers and counts go to 0. Outputs: y0_valid=0, y1_valid=0, cnt0=0, cnt1=0, y0_data=0, y1_data=0. Storage contents are don't-care.
- in_ready = (in_sel ? cnt1 : cnt0) != DEPTH.
  - Depends only on in_sel and registered state.
  - No combinational path from y*_ready to in_ready.
- Push to channel k when in_valid & in_ready & in_sel==k. Store in_data at wr_ptr_k, then wr_ptr_k++ modulo DEPTH.
- The other channel is never written in that cycle.
- Pop from channel k when yk_valid & yk_ready. Then rd_ptr_k++ modulo DEPTH.
- yk_valid = (cntk != 0). yk_data = mem_k[rd_ptr_k] when valid, 0 when empty.
- Latency: a word pushed at edge N appears on yk_valid/yk_data after edge N. Minimum latency is 1 cycle; there is no fall-through.
- Count update per channel:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged. Pointers both advance.
- Full channel (cntk==DEPTH) with in_sel==k: in_ready=0 even if yk_ready=1 that cycle. The producer holds; the pop still happens.
- Empty channel: yk_ready is ignored and no pointer moves.
- Order: FIFO order is preserved within each channel. There is no ordering guarantee across channels.
- Head-of-line: a full channel blocks the producer only while in_sel points at it. Changing in_sel to a non-full channel gives in_ready=1 in the same cycle.
- in_valid=0: no push, regardless of in_sel or in_ready.
- Pointer wrap: natural modulo DEPTH. Counts saturate by construction and never exceed DEPTH.
- Reset asserted mid-operation: all buffered words are discarded and valids drop immediately. The first push after release behaves as from empty.
- Handshake rules: the producer must hold in_data and in_sel stable while in_valid=1 and in_ready=0. Consumers may toggle yk_ready freely.

Test Plan:
- Reset, then push 0x5 to ch0 and 0xA to ch1 in consecutive cycles with y*_ready=0. Required:
  - y0_valid=1, y0_data=0x5 one cycle after the first push; y1_data=0xA one cycle after the second.
  - cnt0=1, cnt1=1.
- Fill ch0 with 0x1, 0x2 (DEPTH=2), y0_ready=0, then drive in_sel=0. Required:
  - in_ready=0 and cnt0=2.
  - Switching in_sel=1 gives in_ready=1 the same cycle.
  - Pushing 0x3 lands in ch1.
- ch0 full, y0_ready=1 and in_valid=1 with in_sel=0 in the same cycle. Required:
  - Pop of 0x1 occurs and in_ready stays 0 that cycle.
  - Next cycle in_ready=1, and pushing 0x4 gives drain order 0x2, 0x4.
- Steady stream of 0x0..0xF to ch1 with y1_ready=1 every cycle. Required:
  - cnt1 stays at 1 after the first word.
  - Output order is 0x0..0xF, in_ready is never 0, and the pointers wrap correctly.
- Assert rst mid-stream with cnt0=2, cnt1=1. Required:
  - y0_valid and y1_valid fall to 0 asynchronously, before the next clock edge.
  - After release, cnt0=cnt1=0 and a new push 0x7 appears one cycle later.
- in_valid=0 with random in_sel for 10 cycles. Required: counts unchanged and no writes occur.
